// File: rtl/calc_pkg.sv
// Shared definitions for the calculator datapath: operation encodings,
// operand/result widths and the sequencer state type.
package calc_pkg;

    localparam int OPND_W = 3;
    localparam int RES_W  = 5;

    localparam logic [1:0] OP_MUL = 2'b00;
    localparam logic [1:0] OP_REM = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SUB = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        DONE  = 2'b10
    } seq_state_t;

    // True for a remainder request whose divisor is zero.
    function automatic logic is_dz_req(input logic [1:0] op, input logic [OPND_W-1:0] b);
        return (op == OP_REM) && (b == '0);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. The pointer remembers the last granted
// requester; on contention the other requester wins, so continuous
// requesters alternate strictly.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant,
    output logic       grant_id
);

    logic ptr;

    // Winner selection: non-pointer requester on contention, else the lone requester.
    always_comb begin
        grant    = 2'b00;
        grant_id = 1'b0;
        if (req == 2'b11) begin
            grant_id = ~ptr;
            grant    = ptr ? 2'b01 : 2'b10;
        end else if (req[1]) begin
            grant_id = 1'b1;
            grant    = 2'b10;
        end else if (req[0]) begin
            grant_id = 1'b0;
            grant    = 2'b01;
        end
    end

    // Pointer tracks the last accepted requester; resets to 1 so requester 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= 1'b1;
        end else if (advance) begin
            ptr <= grant_id;
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Shares the combinational calculator ALU between two requesters.
// Requests are granted round-robin, issued to the ALU from registers for one
// full cycle, and the result is returned as a tagged response.
// Optional feature macro: ALU_SEQ_DZ_TRAP_EN -- when defined, a remainder by
// zero is trapped at accept and answered directly without using the ALU.
module alu_sequencer
    import calc_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [1:0]        req_op0,
    input  logic [1:0]        req_op1,
    input  logic [OPND_W-1:0] req_a0,
    input  logic [OPND_W-1:0] req_a1,
    input  logic [OPND_W-1:0] req_b0,
    input  logic [OPND_W-1:0] req_b1,
    output logic [1:0]        alu_s,
    output logic [OPND_W-1:0] alu_a,
    output logic [OPND_W-1:0] alu_b,
    input  logic [RES_W-1:0]  alu_answer,
    input  logic              alu_dz,
    input  logic              alu_z,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [RES_W-1:0]  rsp_answer,
    output logic              rsp_dz,
    output logic              rsp_z,
    output logic              rsp_err,
    output logic [CNT_W-1:0]  op_count
);

    seq_state_t        state;
    seq_state_t        state_nxt;
    logic [1:0]        grant;
    logic              grant_id;
    logic              accept;
    logic              rsp_hs;
    logic              trap;
    logic [1:0]        sel_op;
    logic [OPND_W-1:0] sel_a;
    logic [OPND_W-1:0] sel_b;

    rr_arb2 u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req_valid),
        .advance  (accept),
        .grant    (grant),
        .grant_id (grant_id)
    );

    // Route the winning requester's operation and operands toward the ALU registers.
    always_comb begin
        sel_op = grant_id ? req_op1 : req_op0;
        sel_a  = grant_id ? req_a1  : req_a0;
        sel_b  = grant_id ? req_b1  : req_b0;
    end

`ifdef ALU_SEQ_DZ_TRAP_EN
    assign trap = is_dz_req(sel_op, sel_b);
`else
    assign trap = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and handshakes; req_ready is masked during reset because it
    // is combinational on req_valid.
    always_comb begin
        state_nxt = state;
        req_ready = 2'b00;
        rsp_valid = 1'b0;
        accept    = 1'b0;
        rsp_hs    = 1'b0;
        case (state)
            IDLE: begin
                if (rst_n && (req_valid != 2'b00)) begin
                    req_ready = grant;
                    accept    = 1'b1;
                    state_nxt = trap ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                state_nxt = DONE;
            end
            DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    rsp_hs    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ALU operand registers, response capture and completed-operation counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_s      <= OP_MUL;
            alu_a      <= '0;
            alu_b      <= '0;
            rsp_id     <= 1'b0;
            rsp_answer <= '0;
            rsp_dz     <= 1'b0;
            rsp_z      <= 1'b0;
            op_count   <= '0;
        end else begin
            if (accept) begin
                rsp_id <= grant_id;
                if (trap) begin
                    rsp_answer <= '0;
                    rsp_dz     <= 1'b1;
                    rsp_z      <= 1'b0;
                end else begin
                    alu_s <= sel_op;
                    alu_a <= sel_a;
                    alu_b <= sel_b;
                end
            end
            if (state == ISSUE) begin
                rsp_answer <= alu_answer;
                rsp_dz     <= alu_dz;
                rsp_z      <= alu_z;
            end
            if (rsp_hs) begin
                op_count <= op_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

`ifdef ALU_SEQ_DZ_TRAP_EN
    logic err_q;

    // Error flag marks a trapped response; cleared by every normally issued request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= trap;
        end
    end

    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Testbench for alu_sequencer: directed scenarios followed by randomized
// traffic, checked every cycle against a transaction-level reference model.
// Honours ALU_SEQ_DZ_TRAP_EN when it is defined for the build.
module tb_alu_sequencer;
    import calc_pkg::*;

    localparam int CNT_W = 2;

`ifdef ALU_SEQ_DZ_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0]       req_op0, req_op1;
    logic [2:0]       req_a0, req_a1, req_b0, req_b1;
    logic [1:0]       alu_s;
    logic [2:0]       alu_a, alu_b;
    logic [4:0]       alu_answer;
    logic             alu_dz, alu_z;
    logic             rsp_valid, rsp_ready, rsp_id;
    logic [4:0]       rsp_answer;
    logic             rsp_dz, rsp_z, rsp_err;
    logic [CNT_W-1:0] op_count;

    int checks = 0;
    int errors = 0;

    alu_sequencer #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op0    (req_op0),
        .req_op1    (req_op1),
        .req_a0     (req_a0),
        .req_a1     (req_a1),
        .req_b0     (req_b0),
        .req_b1     (req_b1),
        .alu_s      (alu_s),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_answer (alu_answer),
        .alu_dz     (alu_dz),
        .alu_z      (alu_z),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_answer (rsp_answer),
        .rsp_dz     (rsp_dz),
        .rsp_z      (rsp_z),
        .rsp_err    (rsp_err),
        .op_count   (op_count)
    );

    always #5 clk = ~clk;

    // Calculator ALU behaviour: returns {dz, z, answer[4:0]}.
    function automatic logic [6:0] aluRef(input logic [1:0] op, input logic [2:0] a, input logic [2:0] b);
        int  r;
        logic dz;
        dz = 1'b0;
        case (op)
            OP_MUL:  r = int'(a) * int'(b);
            OP_REM:  if (b == 3'd0) begin r = 0; dz = 1'b1; end else r = int'(a) % int'(b);
            OP_ADD:  r = int'(a) + int'(b);
            default: r = int'(a) - int'(b);
        endcase
        r = r & 31;
        return {dz, (r == 0), r[4:0]};
    endfunction

    // The ALU seen by the sequencer.
    always_comb {alu_dz, alu_z, alu_answer} = aluRef(alu_s, alu_a, alu_b);

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Round-robin outcome: on contention the requester other than the last winner.
    function automatic logic [1:0] pickWinner(input logic [1:0] v, input logic last);
        if (v == 2'b11) return last ? 2'b01 : 2'b10;
        return v;
    endfunction

    // Reference model: one outstanding transaction with an age in cycles since accept.
    bit         mBusy = 1'b0;
    int         mAge = 0;
    bit         mTrap = 1'b0;
    logic       mPtr = 1'b1;
    int         mCount = 0;
    logic       mId = 1'b0;
    logic [4:0] mAns = '0;
    logic       mDz = 1'b0, mZ = 1'b0, mErr = 1'b0;
    logic [1:0] mAluS = '0;
    logic [2:0] mAluA = '0, mAluB = '0;
    logic [1:0] expReady;
    logic       expValid;
    logic [1:0] wOp;
    logic [2:0] wA, wB;
    logic [6:0] wRes;

    // Compare DUT outputs against the model every cycle, then advance the model across the next edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            checkOutput("reset_req_ready", req_ready, 0);
            checkOutput("reset_rsp_valid", rsp_valid, 0);
            checkOutput("reset_rsp_id", rsp_id, 0);
            checkOutput("reset_rsp_answer", rsp_answer, 0);
            checkOutput("reset_rsp_dz", rsp_dz, 0);
            checkOutput("reset_rsp_z", rsp_z, 0);
            checkOutput("reset_rsp_err", rsp_err, 0);
            checkOutput("reset_op_count", op_count, 0);
            checkOutput("reset_alu_s", alu_s, 0);
            checkOutput("reset_alu_a", alu_a, 0);
            checkOutput("reset_alu_b", alu_b, 0);
            mBusy = 1'b0; mPtr = 1'b1; mCount = 0;
            mAluS = '0; mAluA = '0; mAluB = '0;
        end else begin
            expValid = mBusy && (mAge >= (mTrap ? 1 : 2));
            expReady = mBusy ? 2'b00 : pickWinner(req_valid, mPtr);
            checkOutput("req_ready", req_ready, expReady);
            checkOutput("rsp_valid", rsp_valid, expValid);
            checkOutput("op_count", op_count, mCount);
            checkOutput("alu_s", alu_s, mAluS);
            checkOutput("alu_a", alu_a, mAluA);
            checkOutput("alu_b", alu_b, mAluB);
            if (expValid) begin
                checkOutput("rsp_id", rsp_id, mId);
                checkOutput("rsp_answer", rsp_answer, mAns);
                checkOutput("rsp_dz", rsp_dz, mDz);
                checkOutput("rsp_z", rsp_z, mZ);
                checkOutput("rsp_err", rsp_err, mErr);
            end
            if (expValid && rsp_ready) begin
                mBusy  = 1'b0;
                mCount = (mCount + 1) % (1 << CNT_W);
            end else if (mBusy) begin
                mAge++;
            end else if (expReady != 2'b00) begin
                mId   = expReady[1];
                mPtr  = mId;
                wOp   = mId ? req_op1 : req_op0;
                wA    = mId ? req_a1 : req_a0;
                wB    = mId ? req_b1 : req_b0;
                mTrap = TRAP_EN && (wOp == 2'b01) && (wB == 3'd0);
                wRes  = aluRef(wOp, wA, wB);
                if (mTrap) begin
                    mAns = 5'd0; mDz = 1'b1; mZ = 1'b0; mErr = 1'b1;
                end else begin
                    mAns = wRes[4:0]; mDz = wRes[6]; mZ = wRes[5]; mErr = 1'b0;
                    mAluS = wOp; mAluA = wA; mAluB = wB;
                end
                mBusy = 1'b1;
                mAge  = 1;
            end
        end
    end

    // Run one full transaction on requester id, releasing rsp_ready after hold cycles of valid.
    task automatic applyStimulus(input bit id, input logic [1:0] op, input logic [2:0] a,
                                 input logic [2:0] b, input int hold,
                                 output logic [1:0] sIssue, output int lat, output logic rId,
                                 output logic [4:0] rAns, output logic rDz, output logic rErr);
        int n;
        @(posedge clk); #1;
        if (id) begin req_op1 = op; req_a1 = a; req_b1 = b; end
        else    begin req_op0 = op; req_a0 = a; req_b0 = b; end
        req_valid[id] = 1'b1;
        rsp_ready = (hold == 0);
        n = 0;
        @(negedge clk);
        while (!req_ready[id] && n < 20) begin @(negedge clk); n++; end
        checkOutput("accept_seen", req_ready[id], 1);
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
        @(negedge clk);
        sIssue = alu_s;
        lat = 1;
        while (!rsp_valid && lat < 10) begin @(negedge clk); lat++; end
        checkOutput("response_seen", rsp_valid, 1);
        rId = rsp_id; rAns = rsp_answer; rDz = rsp_dz; rErr = rsp_err;
        if (hold > 0) begin
            repeat (hold) @(posedge clk);
            #1;
            rsp_ready = 1'b1;
        end
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [1:0] sIssue;
        int         lat;
        logic       rId, rDz, rErr;
        logic [4:0] rAns;
        logic       ids [4];
        int         n, hs;

        rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 1'b0;
        req_op0 = '0; req_op1 = '0; req_a0 = '0; req_a1 = '0; req_b0 = '0; req_b1 = '0;
        for (int i = 0; i < 4; i++) ids[i] = 1'bx;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        $display("[TB] single add");
        applyStimulus(1'b0, OP_ADD, 3'd3, 3'd2, 0, sIssue, lat, rId, rAns, rDz, rErr);
        checkOutput("add_alu_s_issue", sIssue, 2'b10);
        checkOutput("add_latency", lat, 2);
        checkOutput("add_rsp_id", rId, 0);
        checkOutput("add_rsp_answer", rAns, 5);
        @(negedge clk);
        checkOutput("add_op_count", op_count, 1);

        $display("[TB] back-pressure");
        applyStimulus(1'b1, OP_SUB, 3'd6, 3'd1, 5, sIssue, lat, rId, rAns, rDz, rErr);
        checkOutput("bp_latency", lat, 2);
        checkOutput("bp_rsp_id", rId, 1);
        checkOutput("bp_rsp_answer", rAns, 5);

        $display("[TB] divide by zero");
        applyStimulus(1'b1, OP_REM, 3'd5, 3'd0, 0, sIssue, lat, rId, rAns, rDz, rErr);
        checkOutput("dz_latency", lat, TRAP_EN ? 1 : 2);
        checkOutput("dz_alu_s", sIssue, TRAP_EN ? 2'b11 : 2'b01);
        checkOutput("dz_rsp_dz", rDz, 1);
        checkOutput("dz_rsp_err", rErr, TRAP_EN);
        checkOutput("dz_rsp_answer", rAns, 0);

        $display("[TB] reset during issue");
        @(posedge clk); #1;
        req_op0 = OP_ADD; req_a0 = 3'd1; req_b0 = 3'd1; req_valid = 2'b01; rsp_ready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!req_ready[0] && n < 20) begin @(negedge clk); n++; end
        checkOutput("midrst_accept", req_ready[0], 1);
        @(posedge clk); #2;
        rst_n = 1'b0; req_valid = 2'b00;
        #1;
        checkOutput("midrst_rsp_valid", rsp_valid, 0);
        checkOutput("midrst_rsp_id", rsp_id, 0);
        checkOutput("midrst_alu_s", alu_s, 0);
        checkOutput("midrst_alu_a", alu_a, 0);
        checkOutput("midrst_alu_b", alu_b, 0);
        checkOutput("midrst_op_count", op_count, 0);
        checkOutput("midrst_req_ready", req_ready, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        $display("[TB] contention");
        req_op0 = OP_ADD; req_a0 = 3'd1; req_b0 = 3'd2;
        req_op1 = OP_MUL; req_a1 = 3'd2; req_b1 = 3'd3;
        req_valid = 2'b11; rsp_ready = 1'b1;
        hs = 0; n = 0;
        while (hs < 4 && n < 60) begin
            @(negedge clk);
            n++;
            if (rsp_valid && rsp_ready) begin ids[hs] = rsp_id; hs++; end
        end
        checkOutput("contention_count", hs, 4);
        @(posedge clk); #1;
        req_valid = 2'b00; rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) checkOutput("contention_order", ids[i], i % 2);
        @(negedge clk);
        checkOutput("wrap_after_four", op_count, 0);
        applyStimulus(1'b0, OP_ADD, 3'd2, 3'd2, 0, sIssue, lat, rId, rAns, rDz, rErr);
        checkOutput("wrap_answer", rAns, 4);
        @(negedge clk);
        checkOutput("wrap_op_count", op_count, 1);

        $display("[TB] randomized traffic");
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk); #1;
            rst_n     = 1'b1;
            req_valid = 2'($urandom_range(0, 3));
            req_op0   = 2'($urandom_range(0, 3));
            req_op1   = 2'($urandom_range(0, 3));
            req_a0    = 3'($urandom_range(0, 7));
            req_a1    = 3'($urandom_range(0, 7));
            req_b0    = ($urandom_range(0, 3) == 0) ? 3'd0 : 3'($urandom_range(0, 7));
            req_b1    = ($urandom_range(0, 3) == 0) ? 3'd0 : 3'($urandom_range(0, 7));
            rsp_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 199) == 0) begin
                #2 rst_n = 1'b0;
            end
        end
        @(posedge clk); #1;
        rst_n = 1'b1; req_valid = 2'b00; rsp_ready = 1'b1;
        repeat (10) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
